// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock prescaler.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } div_state_t;

  localparam int DIV_W_DEF   = 8;
  localparam int RST_DIV_DEF = 4;

endpackage

// File: rtl/clk_div_cnt.sv
// Half-period counter: counts 0..cur_n-1 while enabled and flags the terminal count.
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] cur_n,
  output logic             tc
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_reg;

  // cur_n is never 0 while enabled, so cur_n-1 cannot wrap here.
  assign tc = en && (cnt_reg == (cur_n - ONE));

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (!en || tc) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + ONE;
    end
  end

endmodule

// File: rtl/clk_prescale_prog.sv
// Programmable 50%-duty prescaler with glitch-free ratio updates via load/ack.
// Optional output gating (gate_en port) is built when CLK_GATE_EN is defined.
module clk_prescale_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int RST_DIV = RST_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLK_GATE_EN
  input  logic             gate_en,
`endif
  output logic             div_ack,
  output logic             busy,
  output logic             clk_out,
  output logic             tick
);

  localparam div_state_t RST_STATE = (RST_DIV != 0) ? RUN : STOP;

  div_state_t       state_reg;
  logic [DIV_W-1:0] cur_n_reg;
  logic [DIV_W-1:0] pend_n_reg;
  logic             clk_out_reg;
  logic             tick_reg;
  logic             div_ack_reg;
  logic             busy_reg;
  logic             gated;
  logic             cnt_en;
  logic             tc;
  logic             fall_edge;
  logic             apply;

  assign cnt_en    = (state_reg != STOP) && !gated;
  assign fall_edge = tc && clk_out_reg;
  // A waiting ratio lands only at the end of a full period, or at once if the output is parked.
  assign apply     = (state_reg == PEND) && (fall_edge || gated);

  clk_div_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (cnt_en),
    .cur_n  (cur_n_reg),
    .tc     (tc)
  );

`ifdef CLK_GATE_EN
  logic gated_reg;

  // Gating only takes hold at a 1->0 toggle so the high phase is never truncated.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      gated_reg <= 1'b0;
    end else if (gated_reg) begin
      if (gate_en) gated_reg <= 1'b0;
    end else if (fall_edge && !gate_en) begin
      gated_reg <= 1'b1;
    end
  end

  assign gated = gated_reg;
`else
  assign gated = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_reg   <= RST_STATE;
      cur_n_reg   <= DIV_W'(RST_DIV);
      pend_n_reg  <= '0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
      div_ack_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      tick_reg    <= 1'b0;
      div_ack_reg <= 1'b0;
      if (tc) begin
        clk_out_reg <= ~clk_out_reg;
        tick_reg    <= ~clk_out_reg;
      end
      case (state_reg)
        STOP: begin
          if (div_load && !busy_reg) begin
            cur_n_reg   <= div_val;
            div_ack_reg <= 1'b1;
            state_reg   <= (div_val == '0) ? STOP : RUN;
          end
        end
        RUN: begin
          if (div_load && !busy_reg) begin
            pend_n_reg <= div_val;
            busy_reg   <= 1'b1;
            state_reg  <= PEND;
          end
        end
        PEND: begin
          if (apply) begin
            cur_n_reg   <= pend_n_reg;
            div_ack_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= (pend_n_reg == '0) ? STOP : RUN;
          end
        end
        default: begin
          state_reg <= STOP;
        end
      endcase
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign div_ack = div_ack_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_clk_prescale_prog.sv
// Scoreboard bench: stimulus predicts outputs from elapsed-time arithmetic, a monitor compares.
module tb_clk_prescale_prog;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       div_load = 1'b0;
  logic       div_ack;
  logic       busy;
  logic       clk_out;
  logic       tick;
`ifdef CLK_GATE_EN
  logic       gate_en = 1'b1;
`endif

  clk_prescale_prog #(
    .DIV_W   (8),
    .RST_DIV (4)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .div_val  (div_val),
    .div_load (div_load),
`ifdef CLK_GATE_EN
    .gate_en  (gate_en),
`endif
    .div_ack  (div_ack),
    .busy     (busy),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int cyc;
    bit clk_out;
    bit tick;
    bit ack;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Reference model: segment of k edges at ratio m_n; output level is (k/n) mod 2.
  bit m_run = 1'b1;
  int m_n   = 4;
  int m_k   = 0;
  bit m_pend = 1'b0;
  int m_pv  = 0;

  task automatic cycle(input bit ld, input int v, input bit r);
    exp_t e;
    @(negedge clk_in);
    div_load = ld;
    div_val  = 8'(v);
    if (!r && rst) begin
      rst = 1'b0;
      #1;
      checks++;
      if ({clk_out, tick, div_ack, busy} != 4'b0000) begin
        errors++;
        $display("FAIL async_reset cyc=%0d got clk_out=%0b tick=%0b ack=%0b busy=%0b want all 0",
                 cyc_no, clk_out, tick, div_ack, busy);
      end
    end else begin
      rst = r;
    end
    e.tick = 1'b0;
    e.ack  = 1'b0;
    if (!r) begin
      m_run = 1'b1; m_n = 4; m_k = 0; m_pend = 1'b0;
      e.clk_out = 1'b0;
    end else if (!m_run) begin
      e.clk_out = 1'b0;
      if (ld) begin
        m_n = v; m_run = (v != 0); m_k = 0; e.ack = 1'b1;
      end
    end else begin
      m_k++;
      e.clk_out = ((m_k / m_n) % 2) == 1;
      e.tick    = (m_k % (2 * m_n)) == m_n;
      if (m_pend) begin
        if ((m_k % (2 * m_n)) == 0) begin
          m_n = m_pv; m_run = (m_pv != 0); m_k = 0; m_pend = 1'b0; e.ack = 1'b1;
        end
      end else if (ld) begin
        m_pend = 1'b1; m_pv = v;
      end
    end
    e.busy = m_pend;
    e.cyc  = cyc_no;
    cyc_no++;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per clock edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (clk_out !== e.clk_out || tick !== e.tick || div_ack !== e.ack || busy !== e.busy) begin
          errors++;
          $display("FAIL cycle_outputs cyc=%0d got clk_out=%0b tick=%0b ack=%0b busy=%0b want clk_out=%0b tick=%0b ack=%0b busy=%0b",
                   e.cyc, clk_out, tick, div_ack, busy, e.clk_out, e.tick, e.ack, e.busy);
        end
      end
    end
  end

  initial begin
    repeat (3) cycle(1'b0, 0, 1'b0);
    repeat (5) cycle(1'b0, 0, 1'b1);
    // ratio 2 requested mid-high-phase
    cycle(1'b1, 2, 1'b1);
    repeat (24) cycle(1'b0, 0, 1'b1);
    // second request while busy must be ignored
    cycle(1'b1, 4, 1'b1);
    cycle(1'b1, 7, 1'b1);
    repeat (30) cycle(1'b0, 0, 1'b1);
    // stop, then restart from STOP with ratio 3
    cycle(1'b1, 0, 1'b1);
    repeat (20) cycle(1'b0, 0, 1'b1);
    cycle(1'b1, 3, 1'b1);
    repeat (20) cycle(1'b0, 0, 1'b1);
    // reset while a request is pending
    cycle(1'b1, 5, 1'b1);
    repeat (3) cycle(1'b0, 0, 1'b1);
    repeat (2) cycle(1'b0, 0, 1'b0);
    repeat (30) cycle(1'b0, 0, 1'b1);
    // randomized traffic, including back-to-back loads and rare resets
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 11) == 0, int'($urandom_range(0, 9)),
            $urandom_range(0, 399) != 0);
    end
    @(negedge clk_in);
    div_load = 1'b0;
    repeat (4) @(negedge clk_in);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
